controle_bomba: RTL and testbench
=================================

# controle_bomba

Top-level sequencer for the time-bomb game. It arms on a button press, counts remaining seconds down from a preset, and declares a win when the correct code arrives. At zero it drives the explosion animator with one-cycle step strobes. It also owns the 8-digit HEX and 18-LED outputs, selecting between the countdown display path and the explosion animator according to game state.

## Interface
- TICK_DIV, 50_000_000: CLOCK cycles per second tick (≥2)
- ANIM_DIV, 6_250_000: CLOCK cycles per animation step strobe (≥2)
- CLOCK  in  1  system clock
- RESET  in  1  reset; one clock; reset is synchronous and active-high
- ARMAR  in  1  arm button, level; rising edge detected internally
- CODIGO_OK  in  1  correct-code flag, level; rising edge detected internally
- TEMPO_INICIAL  in  14  start value in seconds; 0 = invalid; >9999 clamped to 9999
- CONTAGEM_HEX  in  56  countdown display segments, digit k at [7k+6:7k], active-low
- EXPLOSAO_HEX  in  56  animator segments, same packing
- EXPLOSAO_LEDR  in  18  animator LEDs
- SEGUNDOS  out  14  remaining seconds, binary
- TICK_SEG  out  1  one-cycle pulse on each second decrement
- TEMPO_ACABOU  out  1  one-cycle animation step strobe, only while exploding
- ESTADO  out  2  0 OCIOSO, 1 CONTANDO, 2 EXPLODINDO, 3 DESARMADO
- HEX  out  56  selected segments, registered
- LEDR  out  18  selected LEDs, registered

## Operation
- Edge detect
  - arm_ev = ARMAR & ~armar_q; ok_ev = CODIGO_OK & ~ok_q.
  - Both history flops reset to 1, so an input held high through reset does not fire.
- Arming is valid only if TEMPO_INICIAL ≠ 0. A valid arm from any state except CONTANDO does all of the following:
  - sets ESTADO = CONTANDO;
  - loads SEGUNDOS with min(TEMPO_INICIAL, 9999);
  - clears both prescalers.
- Arming with TEMPO_INICIAL = 0 is ignored. arm_ev in CONTANDO is ignored.
- CONTANDO
  - Second prescaler counts 0..TICK_DIV-1. At TICK_DIV-1 it wraps to 0, pulses TICK_SEG and decrements SEGUNDOS.
  - If the decrement produces 0, go to EXPLODINDO on the same edge.
  - ok_ev goes to DESARMADO and freezes SEGUNDOS.
  - ok_ev has priority over a coincident tick: no decrement, no TICK_SEG, no explosion.
- EXPLODINDO
  - Animation prescaler counts 0..ANIM_DIV-1 and pulses TEMPO_ACABOU at wrap.
  - SEGUNDOS holds 0. ok_ev is ignored.
  - The state persists until RESET or a valid arm.
- DESARMADO: SEGUNDOS frozen, counters idle, leaves only on RESET or a valid arm.
- Output select, registered each cycle:
  - EXPLODINDO: HEX = EXPLOSAO_HEX, LEDR = EXPLOSAO_LEDR.
  - DESARMADO: HEX = CONTAGEM_HEX, LEDR = 18'h3FFFF.
  - OCIOSO / CONTANDO: HEX = CONTAGEM_HEX, LEDR = 0.
- Arithmetic: SEGUNDOS never underflows, and decrement occurs only when SEGUNDOS ≥ 1. Prescaler widths are $clog2 of their divisors.

## Timing
- Reset values: ESTADO 0, SEGUNDOS 0, TICK_SEG 0, TEMPO_ACABOU 0, HEX all ones (56'hFF_FFFF_FFFF_FFFF, blank), LEDR 0, prescalers 0.
- RESET mid-operation returns to OCIOSO on the next edge regardless of state, with the values above.
- An arm sampled at edge N is visible after edge N (ESTADO = 1, SEGUNDOS loaded).
- The first TICK_SEG is high in the cycle after edge N+TICK_DIV. Subsequent ticks come every TICK_DIV cycles.
- The zero transition shows SEGUNDOS = 0 and ESTADO = 2 together after the same edge.
- The first TEMPO_ACABOU comes ANIM_DIV cycles after entering EXPLODINDO, then every ANIM_DIV cycles. It is never held for more than 1 cycle.
- HEX/LEDR lag ESTADO by exactly 1 cycle (registered mux of registered state).
- A valid re-arm from EXPLODINDO suppresses any strobe due that cycle; TEMPO_ACABOU is 0 from the arm edge onward.

## Test plan
All scenarios use TICK_DIV = 10 and ANIM_DIV = 4.
- Reset, then hold ARMAR = 1 from reset release with TEMPO_INICIAL = 3 → no arming. Drop ARMAR, raise it → ESTADO 1, SEGUNDOS 3; TICK_SEG pulses 10, 20, 30 cycles later; SEGUNDOS goes 2, 1, 0; ESTADO 2 with the last tick.
- In EXPLODINDO for 17 cycles → TEMPO_ACABOU pulses exactly at cycles 4, 8, 12, 16. HEX/LEDR equal EXPLOSAO_HEX/EXPLOSAO_LEDR delayed 1 cycle. CODIGO_OK edge has no effect.
- Arm with 5 and raise CODIGO_OK on the exact cycle of the 2nd tick → no TICK_SEG that cycle, SEGUNDOS stays 4, ESTADO 3, LEDR 3FFFF one cycle later.
- Arm with TEMPO_INICIAL = 0 → ESTADO stays 0. Arm with 16383 → SEGUNDOS 9999.
- Assert RESET mid-count (SEGUNDOS 7) and mid-explosion → next edge ESTADO 0, SEGUNDOS 0, HEX all ones, LEDR 0, no strobes.
- From DESARMADO and from EXPLODINDO, an ARMAR edge with TEMPO_INICIAL = 2 → ESTADO 1, SEGUNDOS 2, prescalers restart (first tick 10 cycles later).

Source files
------------

// File: rtl/controle_bomba.sv
// Time-bomb game sequencer: arms on a button edge, counts seconds down, defuses on a code edge,
// and drives the explosion animator with step strobes once the count reaches zero.
module controle_bomba #(
  parameter int TICK_DIV = 50_000_000,
  parameter int ANIM_DIV = 6_250_000
) (
  input  logic        CLOCK,
  input  logic        RESET,
  input  logic        ARMAR,
  input  logic        CODIGO_OK,
  input  logic [13:0] TEMPO_INICIAL,
  input  logic [55:0] CONTAGEM_HEX,
  input  logic [55:0] EXPLOSAO_HEX,
  input  logic [17:0] EXPLOSAO_LEDR,
  output logic [13:0] SEGUNDOS,
  output logic        TICK_SEG,
  output logic        TEMPO_ACABOU,
  output logic [1:0]  ESTADO,
  output logic [55:0] HEX,
  output logic [17:0] LEDR
);

  typedef enum logic [1:0] {
    OCIOSO     = 2'd0,
    CONTANDO   = 2'd1,
    EXPLODINDO = 2'd2,
    DESARMADO  = 2'd3
  } estado_t;

  localparam int TW = $clog2(TICK_DIV);
  localparam int AW = $clog2(ANIM_DIV);
  localparam logic [TW-1:0] TICK_MAX = TW'(TICK_DIV - 1);
  localparam logic [AW-1:0] ANIM_MAX = AW'(ANIM_DIV - 1);
  localparam logic [13:0]   SEG_MAX  = 14'd9999;

  estado_t       state_q;
  estado_t       state_d;
  logic          armar_q;
  logic          ok_q;
  logic [TW-1:0] tick_cnt;
  logic [AW-1:0] anim_cnt;
  logic [13:0]   segundos_q;
  logic          tick_seg_q;
  logic          tempo_acabou_q;
  logic [55:0]   hex_q;
  logic [17:0]   ledr_q;
  logic [55:0]   hex_sel;
  logic [17:0]   ledr_sel;

  logic        arm_ev;
  logic        ok_ev;
  logic        arm_valido;
  logic        tick_wrap;
  logic        anim_wrap;
  logic        do_tick;
  logic [13:0] tempo_clamp;

  // History flops reset high so a level already asserted at reset release never counts as an edge.
  assign arm_ev      = ARMAR & ~armar_q;
  assign ok_ev       = CODIGO_OK & ~ok_q;
  assign arm_valido  = arm_ev && (TEMPO_INICIAL != 14'd0) && (state_q != CONTANDO);
  assign tempo_clamp = (TEMPO_INICIAL > SEG_MAX) ? SEG_MAX : TEMPO_INICIAL;
  assign tick_wrap   = (state_q == CONTANDO) && (tick_cnt == TICK_MAX);
  assign anim_wrap   = (state_q == EXPLODINDO) && (anim_cnt == ANIM_MAX);
  // A coincident code edge wins over the second tick.
  assign do_tick     = tick_wrap && !ok_ev && (segundos_q != 14'd0);

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state_q <= OCIOSO;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (arm_valido) begin
      state_d = CONTANDO;
    end else begin
      case (state_q)
        CONTANDO: begin
          if (ok_ev) begin
            state_d = DESARMADO;
          end else if (do_tick && (segundos_q == 14'd1)) begin
            state_d = EXPLODINDO;
          end
        end
        default: state_d = state_q;
      endcase
    end
  end

  always_comb begin
    hex_sel  = CONTAGEM_HEX;
    ledr_sel = 18'd0;
    case (state_q)
      EXPLODINDO: begin
        hex_sel  = EXPLOSAO_HEX;
        ledr_sel = EXPLOSAO_LEDR;
      end
      DESARMADO: ledr_sel = 18'h3FFFF;
      default: ;
    endcase
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      armar_q        <= 1'b1;
      ok_q           <= 1'b1;
      tick_cnt       <= '0;
      anim_cnt       <= '0;
      segundos_q     <= 14'd0;
      tick_seg_q     <= 1'b0;
      tempo_acabou_q <= 1'b0;
      hex_q          <= {56{1'b1}};
      ledr_q         <= 18'd0;
    end else begin
      armar_q        <= ARMAR;
      ok_q           <= CODIGO_OK;
      tick_seg_q     <= 1'b0;
      tempo_acabou_q <= 1'b0;
      hex_q          <= hex_sel;
      ledr_q         <= ledr_sel;
      if (arm_valido) begin
        segundos_q <= tempo_clamp;
        tick_cnt   <= '0;
        anim_cnt   <= '0;
      end else begin
        case (state_q)
          CONTANDO: begin
            if (!ok_ev) begin
              tick_cnt <= tick_wrap ? '0 : tick_cnt + TW'(1);
              if (do_tick) begin
                segundos_q <= segundos_q - 14'd1;
                tick_seg_q <= 1'b1;
              end
            end
          end
          EXPLODINDO: begin
            anim_cnt       <= anim_wrap ? '0 : anim_cnt + AW'(1);
            tempo_acabou_q <= anim_wrap;
            segundos_q     <= 14'd0;
          end
          default: ;
        endcase
      end
    end
  end

  assign ESTADO       = state_q;
  assign SEGUNDOS     = segundos_q;
  assign TICK_SEG     = tick_seg_q;
  assign TEMPO_ACABOU = tempo_acabou_q;
  assign HEX          = hex_q;
  assign LEDR         = ledr_q;

endmodule

// File: tb/tb_controle_bomba.sv
// Bench for controle_bomba: directed game scenarios followed by random play, all checked
// against a behavioural model that counts elapsed cycles since arming / exploding.
module tb_controle_bomba;

  localparam int TICK_DIV = 10;
  localparam int ANIM_DIV = 4;

  logic        CLOCK = 1'b0;
  logic        RESET;
  logic        ARMAR;
  logic        CODIGO_OK;
  logic [13:0] TEMPO_INICIAL;
  logic [55:0] CONTAGEM_HEX;
  logic [55:0] EXPLOSAO_HEX;
  logic [17:0] EXPLOSAO_LEDR;
  logic [13:0] SEGUNDOS;
  logic        TICK_SEG;
  logic        TEMPO_ACABOU;
  logic [1:0]  ESTADO;
  logic [55:0] HEX;
  logic [17:0] LEDR;

  controle_bomba #(.TICK_DIV(TICK_DIV), .ANIM_DIV(ANIM_DIV)) dut (
    .CLOCK(CLOCK), .RESET(RESET), .ARMAR(ARMAR), .CODIGO_OK(CODIGO_OK),
    .TEMPO_INICIAL(TEMPO_INICIAL), .CONTAGEM_HEX(CONTAGEM_HEX),
    .EXPLOSAO_HEX(EXPLOSAO_HEX), .EXPLOSAO_LEDR(EXPLOSAO_LEDR),
    .SEGUNDOS(SEGUNDOS), .TICK_SEG(TICK_SEG), .TEMPO_ACABOU(TEMPO_ACABOU),
    .ESTADO(ESTADO), .HEX(HEX), .LEDR(LEDR)
  );

  always #5 CLOCK = ~CLOCK;

  int checks = 0;
  int errors = 0;

  // Reference model: game state, seconds left, cycles elapsed since arming / since exploding.
  int          m_state;
  int          m_sec;
  int          m_since_arm;
  int          m_since_boom;
  bit          m_tick;
  bit          m_boom;
  logic [55:0] m_hex;
  logic [17:0] m_ledr;
  bit          m_armar_prev;
  bit          m_ok_prev;

  task automatic chk(input string tag, input logic [55:0] obs, input logic [55:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    bit arm;
    bit ok;
    if (RESET) begin
      m_state = 0; m_sec = 0; m_since_arm = 0; m_since_boom = 0;
      m_tick = 0; m_boom = 0; m_hex = {56{1'b1}}; m_ledr = 18'd0;
      m_armar_prev = 1; m_ok_prev = 1;
      return;
    end
    // Displays follow the state that was current before this edge.
    if (m_state == 2) begin
      m_hex = EXPLOSAO_HEX; m_ledr = EXPLOSAO_LEDR;
    end else if (m_state == 3) begin
      m_hex = CONTAGEM_HEX; m_ledr = 18'h3FFFF;
    end else begin
      m_hex = CONTAGEM_HEX; m_ledr = 18'd0;
    end
    arm = ARMAR && !m_armar_prev;
    ok  = CODIGO_OK && !m_ok_prev;
    m_tick = 0;
    m_boom = 0;
    if (arm && TEMPO_INICIAL != 0 && m_state != 1) begin
      m_state = 1;
      m_sec = (TEMPO_INICIAL > 9999) ? 9999 : int'(TEMPO_INICIAL);
      m_since_arm = 0;
    end else if (m_state == 1) begin
      m_since_arm++;
      if (ok) begin
        m_state = 3;
      end else if (m_since_arm % TICK_DIV == 0 && m_sec > 0) begin
        m_sec--;
        m_tick = 1;
        if (m_sec == 0) begin
          m_state = 2;
          m_since_boom = 0;
        end
      end
    end else if (m_state == 2) begin
      m_since_boom++;
      if (m_since_boom % ANIM_DIV == 0) m_boom = 1;
    end
    m_armar_prev = ARMAR;
    m_ok_prev = CODIGO_OK;
  endtask

  task automatic cycle();
    model_step();
    @(posedge CLOCK);
    #1;
    chk("estado", 56'(ESTADO), 56'(m_state));
    chk("segundos", 56'(SEGUNDOS), 56'(m_sec));
    chk("tick_seg", 56'(TICK_SEG), 56'(m_tick));
    chk("tempo_acabou", 56'(TEMPO_ACABOU), 56'(m_boom));
    chk("hex", HEX, m_hex);
    chk("ledr", 56'(LEDR), 56'(m_ledr));
    CONTAGEM_HEX  = {$urandom, $urandom};
    EXPLOSAO_HEX  = {$urandom, $urandom};
    EXPLOSAO_LEDR = 18'($urandom);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    RESET = 1; ARMAR = 1; CODIGO_OK = 0; TEMPO_INICIAL = 14'd3;
    CONTAGEM_HEX = 56'h0123_4567_89AB_CD; EXPLOSAO_HEX = 56'hAA_5555_AAAA_5555; EXPLOSAO_LEDR = 18'h2AAAA;
    run(2);
    chk("reset_hex", HEX, {56{1'b1}});
    chk("reset_estado", 56'(ESTADO), 56'd0);

    // ARMAR held high across reset release must not arm.
    RESET = 0;
    run(3);
    chk("held_armar_idle", 56'(ESTADO), 56'd0);
    ARMAR = 0; cycle();
    ARMAR = 1; cycle();
    chk("arm_estado", 56'(ESTADO), 56'd1);
    chk("arm_segundos", 56'(SEGUNDOS), 56'd3);
    for (int i = 1; i <= 30; i++) begin
      cycle();
      chk("plan_tick", 56'(TICK_SEG), 56'(i % 10 == 0));
    end
    chk("zero_segundos", 56'(SEGUNDOS), 56'd0);
    chk("zero_estado", 56'(ESTADO), 56'd2);

    // Explosion strobes every ANIM_DIV cycles; a code edge is ignored.
    for (int j = 1; j <= 17; j++) begin
      if (j == 5) CODIGO_OK = 1;
      cycle();
      chk("plan_strobe", 56'(TEMPO_ACABOU), 56'(j % 4 == 0));
    end
    chk("boom_ignores_ok", 56'(ESTADO), 56'd2);

    // Code edge on the exact cycle of the second tick.
    ARMAR = 0; CODIGO_OK = 0; TEMPO_INICIAL = 14'd5; cycle();
    ARMAR = 1; cycle();
    run(19);
    CODIGO_OK = 1; cycle();
    chk("ok_tick_suppressed", 56'(TICK_SEG), 56'd0);
    chk("ok_segundos", 56'(SEGUNDOS), 56'd4);
    chk("ok_estado", 56'(ESTADO), 56'd3);
    cycle();
    chk("ok_ledr", 56'(LEDR), 56'h3FFFF);

    // Re-arm from DESARMADO, count down, then re-arm from EXPLODINDO on a strobe cycle.
    ARMAR = 0; TEMPO_INICIAL = 14'd2; cycle();
    ARMAR = 1; cycle();
    chk("rearm_des_estado", 56'(ESTADO), 56'd1);
    chk("rearm_des_segundos", 56'(SEGUNDOS), 56'd2);
    for (int i = 1; i <= 20; i++) begin
      cycle();
      chk("rearm_tick", 56'(TICK_SEG), 56'(i % 10 == 0));
    end
    chk("rearm_boom", 56'(ESTADO), 56'd2);
    ARMAR = 0; run(3);
    ARMAR = 1; cycle();
    chk("rearm_strobe_suppressed", 56'(TEMPO_ACABOU), 56'd0);
    chk("rearm_boom_estado", 56'(ESTADO), 56'd1);
    chk("rearm_boom_segundos", 56'(SEGUNDOS), 56'd2);
    for (int i = 1; i <= 10; i++) begin
      cycle();
      chk("rearm_boom_tick", 56'(TICK_SEG), 56'(i == 10));
    end

    // Reset mid-count at SEGUNDOS 7.
    RESET = 1; cycle(); RESET = 0;
    ARMAR = 0; TEMPO_INICIAL = 14'd9; cycle();
    ARMAR = 1; run(21);
    chk("midcount_segundos", 56'(SEGUNDOS), 56'd7);
    RESET = 1; cycle();
    chk("midcount_rst_estado", 56'(ESTADO), 56'd0);
    chk("midcount_rst_segundos", 56'(SEGUNDOS), 56'd0);
    chk("midcount_rst_hex", HEX, {56{1'b1}});
    chk("midcount_rst_ledr", 56'(LEDR), 56'd0);
    RESET = 0;

    // Zero start is ignored; oversize start clamps.
    ARMAR = 0; TEMPO_INICIAL = 14'd0; cycle();
    ARMAR = 1; cycle();
    chk("zero_arm_ignored", 56'(ESTADO), 56'd0);
    ARMAR = 0; TEMPO_INICIAL = 14'd16383; cycle();
    ARMAR = 1; cycle();
    chk("clamp_segundos", 56'(SEGUNDOS), 56'd9999);

    // Reset mid-explosion.
    RESET = 1; cycle(); RESET = 0;
    ARMAR = 0; TEMPO_INICIAL = 14'd1; cycle();
    ARMAR = 1; run(11);
    chk("boom_again", 56'(ESTADO), 56'd2);
    run(3);
    RESET = 1; cycle();
    chk("boom_rst_estado", 56'(ESTADO), 56'd0);
    chk("boom_rst_strobe", 56'(TEMPO_ACABOU), 56'd0);
    chk("boom_rst_ledr", 56'(LEDR), 56'd0);
    RESET = 0;

    // Random play.
    for (int n = 0; n < 800; n++) begin
      int r;
      RESET = ($urandom_range(0, 149) == 0);
      if ($urandom_range(0, 19) == 0) ARMAR = ~ARMAR;
      if ($urandom_range(0, 24) == 0) CODIGO_OK = ~CODIGO_OK;
      r = $urandom_range(0, 9);
      if (r == 0) TEMPO_INICIAL = 14'd0;
      else if (r == 1) TEMPO_INICIAL = 14'($urandom_range(9990, 16383));
      else TEMPO_INICIAL = 14'($urandom_range(1, 4));
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
